serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and n_rst.
REQ-002 Parameter NUM_BITS SHALL default to 8 and set the operand width, legal range 2..32.
REQ-003 clk SHALL be an input, 1 bit: rising-edge system clock.
REQ-004 n_rst SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 start SHALL be an input, 1 bit: request to begin an add; sampled on a rising clk edge.
REQ-006 a SHALL be an input, NUM_BITS wide: operand A, captured when start is accepted.
REQ-007 b SHALL be an input, NUM_BITS wide: operand B, captured when start is accepted.
REQ-008 carry_in SHALL be an input, 1 bit: initial carry, captured when start is accepted.
REQ-009 busy SHALL be an output, 1 bit: high while an add is in progress.
REQ-010 done SHALL be an output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 sum SHALL be an output, NUM_BITS wide: registered result.
REQ-012 carry_out SHALL be an output, 1 bit: registered final carry.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, start=1 at a clk edge SHALL load a, b and carry_in into internal registers, clear the bit counter, and move to SHIFT.
REQ-015 In SHIFT, each edge SHALL add exactly one bit position, LSB first: the operand LSBs plus the carry register.
  - sum shifts right, with the new sum bit entering at bit NUM_BITS-1.
  - Both operand registers shift right.
  - The carry register takes the generated carry.
REQ-016 Full-adder logic per bit SHALL be: s = c ^ a_i ^ b_i and c_next = (a_i & b_i) | (c & (a_i | b_i)).
REQ-017 On the edge that processes bit NUM_BITS-1, the FSM SHALL move from SHIFT to DONE.
REQ-018 done SHALL be high only in DONE, for exactly one cycle, and SHALL occur NUM_BITS+1 edges after the start-accepting edge, the accepting edge counted as edge 0.
REQ-019 Without a new start, DONE SHALL go to IDLE on the next edge.
REQ-020 busy SHALL equal 1 exactly when the state is SHIFT.
REQ-021 start while in SHIFT SHALL be ignored, leaving operands, counter and result unaffected.
REQ-022 start in the DONE cycle SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-023 sum and carry_out SHALL be valid from the DONE cycle onward and SHALL hold until the next accepted start.
REQ-024 During SHIFT, sum and carry_out contents are partial and SHALL NOT be relied on.
REQ-025 The result SHALL equal (carry_in + a + b) modulo 2^(NUM_BITS+1), with the MSB of that value on carry_out.
REQ-026 The bit counter SHALL be ceil(log2(NUM_BITS)) bits wide and SHALL never wrap inside one operation.

Reset
REQ-027 While n_rst=0, the block SHALL asynchronously force: state IDLE, counter 0, operand registers 0, carry register 0, sum 0, carry_out 0, busy 0, done 0.
REQ-028 Reset asserted mid-operation SHALL abort the add with no done pulse.
REQ-029 After reset is released, the block SHALL accept start on the first rising edge.

Structure
REQ-030 The state enum typedef (IDLE, SHIFT, DONE) and the default width constant SHALL be placed in shared package serial_adder_pkg.
REQ-031 The per-bit add SHALL be one instance of the existing combinational sub-module adder_1bit (ports a, b, carry_in, sum, carry_out).
REQ-032 All state SHALL be held in flip-flops of the block; no latches are permitted.

Verification (NUM_BITS=8)
REQ-033 a=0x5A, b=0x33, carry_in=0, one-cycle start -> done 9 edges later, sum=0x8D, carry_out=0, busy high for 8 cycles.
REQ-034 a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1; then a=0xFF, b=0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
REQ-035 Start first add 0x10+0x20; pulse start with a=0x77 at bit 3 -> result 0x30, carry_out=0, exactly one done pulse.
REQ-036 Start 0xAA+0x55, drive n_rst=0 at bit 4 -> all outputs 0 immediately, no done; after release, 0x01+0x01 gives 0x02.
REQ-037 Start asserted in the DONE cycle with a=0x80, b=0x80 -> first result held stable in that cycle; second done 9 edges later with sum=0x00, carry_out=1.
REQ-038 Random self-check: 1000 random a, b, carry_in sets compared against the REQ-025 formula, including all-zero and all-one operands.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial adder: the controller
//               state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Operand width used when the instantiating level does not override it.
    localparam int c_DEFAULT_NUM_BITS = 8;

    // Controller states. Explicit 2-bit encoding keeps the register width
    // fixed regardless of tool enum-sizing defaults.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/adder_1bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_1bit
// Description : Combinational one-bit full adder.
// Ports       : a, b      - addend bits
//               carry_in  - incoming carry
//               sum       - a ^ b ^ carry_in
//               carry_out - generated carry
// Revision    : 1.0 - initial release
// ============================================================================
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = carry_in ^ a ^ b;
    assign carry_out = (a & b) | (carry_in & (a | b));

endmodule : adder_1bit
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder. An accepted start captures a, b and
//               carry_in; one bit position is then added per clock, LSB
//               first, through a single full adder. The result is presented
//               on sum/carry_out with a one-cycle done pulse.
// Ports       : clk       - rising-edge system clock
//               n_rst     - asynchronous active-low reset
//               start     - begin an add (ignored while busy)
//               a, b      - NUM_BITS-wide operands
//               carry_in  - initial carry
//               busy      - high while bits are being processed
//               done      - one-cycle pulse, result valid
//               sum       - registered NUM_BITS-wide result
//               carry_out - registered final carry
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int NUM_BITS = c_DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out
);

    localparam int                CNT_W      = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0]  c_LAST_CNT = CNT_W'(NUM_BITS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_BITS-1:0] r_a;
    logic [NUM_BITS-1:0] r_b;
    logic                r_carry;
    logic [NUM_BITS-1:0] r_sum;
    logic                r_carry_out;

    logic                w_load;
    logic                w_last_bit;
    logic                w_bit_sum;
    logic                w_bit_carry;

    // A start is only honoured outside SHIFT; in DONE this gives
    // back-to-back operation without an idle cycle.
    assign w_load     = start && (r_state != SHIFT);
    assign w_last_bit = (r_cnt == c_LAST_CNT);

    adder_1bit u_adder_1bit (
        .a         (r_a[0]),
        .b         (r_b[0]),
        .carry_in  (r_carry),
        .sum       (w_bit_sum),
        .carry_out (w_bit_carry)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = SHIFT;
            end
            SHIFT: begin
                if (w_last_bit) w_next_state = DONE;
            end
            DONE: begin
                w_next_state = start ? SHIFT : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_carry <= carry_in;
        end else if (r_state == SHIFT) begin
            r_a         <= {1'b0, r_a[NUM_BITS-1:1]};
            r_b         <= {1'b0, r_b[NUM_BITS-1:1]};
            r_carry     <= w_bit_carry;
            // New bits enter at the MSB so that after NUM_BITS shifts the
            // first computed bit has arrived at bit 0.
            r_sum       <= {w_bit_sum, r_sum[NUM_BITS-1:1]};
            r_carry_out <= w_bit_carry;
            // Hold at the last index instead of wrapping to zero.
            if (!w_last_bit) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign busy      = (r_state == SHIFT);
    assign done      = (r_state == DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule : serial_adder
`default_nettype wire
